memtrace_lane_scheduler: RTL and testbench

Sits between the per-thread memory-trace reader and a single-ported memory request channel.
- Captures one multi-lane trace bundle at a time.
- Serializes the valid lanes, in ascending thread-id order, onto one valid/ready request port.
- Bounds outstanding requests with a credit counter.
- Raises done once the trace reports finished and all traffic has drained.

---
 rtl/memtrace_sched_pkg.sv | 18 +
 rtl/memtrace_lane_scheduler_if.sv | 46 ++++
 rtl/memtrace_lane_pick.sv | 20 ++
 rtl/memtrace_lane_scheduler.sv | 123 ++++++++++++
 tb/tb_memtrace_lane_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memtrace_sched_pkg.sv
// memtrace_sched_pkg: shared state encoding, default widths and buffered lane record
// for the memtrace lane scheduler.
package memtrace_sched_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_MASK_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // Lanes are stored at the default widths; narrower configurations zero-extend on capture.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] address;
        logic                      is_store;
        logic [DEF_MASK_WIDTH-1:0] store_mask;
        logic [DEF_DATA_WIDTH-1:0] data;
    } lane_t;

endpackage

// File: rtl/memtrace_lane_scheduler_if.sv
// memtrace_lane_scheduler_if: multi-lane trace bundle in, serialized memory request out.
// master = scheduler side, slave = trace reader / memory side.
interface memtrace_lane_scheduler_if #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = memtrace_sched_pkg::DEF_DATA_WIDTH,
    parameter int MASK_WIDTH  = memtrace_sched_pkg::DEF_MASK_WIDTH
);

    localparam int TID_WIDTH = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic                              trace_read_ready;
    logic [NUM_THREADS-1:0]            trace_read_valid;
    logic [DATA_WIDTH*NUM_THREADS-1:0] trace_read_address;
    logic [NUM_THREADS-1:0]            trace_read_is_store;
    logic [MASK_WIDTH*NUM_THREADS-1:0] trace_read_store_mask;
    logic [DATA_WIDTH*NUM_THREADS-1:0] trace_read_data;
    logic                              trace_read_finished;

    logic                              mem_req_valid;
    logic                              mem_req_ready;
    logic [TID_WIDTH-1:0]              mem_req_tid;
    logic [DATA_WIDTH-1:0]             mem_req_address;
    logic                              mem_req_is_store;
    logic [MASK_WIDTH-1:0]             mem_req_store_mask;
    logic [DATA_WIDTH-1:0]             mem_req_data;
    logic                              mem_resp_valid;

    modport master (
        output trace_read_ready,
        input  trace_read_valid, trace_read_address, trace_read_is_store,
               trace_read_store_mask, trace_read_data, trace_read_finished,
        output mem_req_valid, mem_req_tid, mem_req_address, mem_req_is_store,
               mem_req_store_mask, mem_req_data,
        input  mem_req_ready, mem_resp_valid
    );

    modport slave (
        input  trace_read_ready,
        output trace_read_valid, trace_read_address, trace_read_is_store,
               trace_read_store_mask, trace_read_data, trace_read_finished,
        input  mem_req_valid, mem_req_tid, mem_req_address, mem_req_is_store,
               mem_req_store_mask, mem_req_data,
        output mem_req_ready, mem_resp_valid
    );

endinterface

// File: rtl/memtrace_lane_pick.sv
// memtrace_lane_pick: lowest-set-bit priority encoder, giving the index and an any-set flag.
module memtrace_lane_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = W'(i);
    end

    assign any = |req;

endmodule

// File: rtl/memtrace_lane_scheduler.sv
// memtrace_lane_scheduler: serializes valid trace lanes onto one credit-limited request port.
// Defining MEMTRACE_SCHED_STATS_EN adds saturating request/stall counters.
module memtrace_lane_scheduler
    import memtrace_sched_pkg::*;
#(
    parameter int NUM_THREADS  = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MASK_WIDTH   = DEF_MASK_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    memtrace_lane_scheduler_if.master         bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              done,
    output logic                              err_underflow
`ifdef MEMTRACE_SCHED_STATS_EN
    ,
    output logic [31:0]                       stat_req_count,
    output logic [31:0]                       stat_credit_stall,
    output logic [31:0]                       stat_bp_stall
`endif
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    state_t                 state;
    lane_t                  lanes [NUM_THREADS];
    logic [NUM_THREADS-1:0] pending;
    logic [NUM_THREADS-1:0] pending_next;
    logic                   fin;
    logic                   any;
    logic                   credit;
    logic                   fire;
    logic [TW-1:0]          sel;

    memtrace_lane_pick #(.N(NUM_THREADS), .W(TW)) u_pick (
        .req(pending),
        .idx(sel),
        .any(any)
    );

    assign credit                 = inflight < CW'(MAX_INFLIGHT);
    assign bus.trace_read_ready   = reset && state == IDLE;
    assign bus.mem_req_valid      = reset && state == ISSUE && any && credit;
    assign fire                   = bus.mem_req_valid && bus.mem_req_ready;
    // Issuing always retires the lowest pending lane, so dropping the lowest set bit suffices.
    assign pending_next           = pending & (pending - NUM_THREADS'(1));
    assign bus.mem_req_tid        = sel;
    assign bus.mem_req_address    = lanes[sel].address[DATA_WIDTH-1:0];
    assign bus.mem_req_is_store   = lanes[sel].is_store;
    assign bus.mem_req_store_mask = lanes[sel].store_mask[MASK_WIDTH-1:0];
    assign bus.mem_req_data       = lanes[sel].data[DATA_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            pending       <= '0;
            fin           <= 1'b0;
            inflight      <= '0;
            done          <= 1'b0;
            err_underflow <= 1'b0;
            for (int g = 0; g < NUM_THREADS; g++) lanes[g] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.trace_read_valid) begin
                        for (int g = 0; g < NUM_THREADS; g++)
                            lanes[g] <= '{
                                address:    DEF_DATA_WIDTH'(bus.trace_read_address[DATA_WIDTH*g +: DATA_WIDTH]),
                                is_store:   bus.trace_read_is_store[g],
                                store_mask: DEF_MASK_WIDTH'(bus.trace_read_store_mask[MASK_WIDTH*g +: MASK_WIDTH]),
                                data:       DEF_DATA_WIDTH'(bus.trace_read_data[DATA_WIDTH*g +: DATA_WIDTH])
                            };
                        pending <= bus.trace_read_valid;
                        fin     <= bus.trace_read_finished;
                        state   <= ISSUE;
                    end else if (bus.trace_read_finished) begin
                        state <= DRAIN;
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        pending <= pending_next;
                        if (pending_next == '0) state <= fin ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (inflight == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
            // A simultaneous issue and response cancel; a response with nothing outstanding is flagged.
            if (fire && !bus.mem_resp_valid) begin
                inflight <= inflight + CW'(1);
            end else if (!fire && bus.mem_resp_valid) begin
                if (inflight == '0) err_underflow <= 1'b1;
                else inflight <= inflight - CW'(1);
            end
        end
    end

`ifdef MEMTRACE_SCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_req_count    <= '0;
            stat_credit_stall <= '0;
            stat_bp_stall     <= '0;
        end else begin
            if (fire && !(&stat_req_count)) stat_req_count <= stat_req_count + 32'd1;
            if (state == ISSUE && any && !credit && !(&stat_credit_stall))
                stat_credit_stall <= stat_credit_stall + 32'd1;
            if (bus.mem_req_valid && !bus.mem_req_ready && !(&stat_bp_stall))
                stat_bp_stall <= stat_bp_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memtrace_lane_scheduler.sv
// tb_memtrace_lane_scheduler: scoreboard bench; instance a uses default credits,
// instance b uses MAX_INFLIGHT=2 for the credit-limit scenario.
module tb_memtrace_lane_scheduler;

    typedef struct {
        logic [1:0]  tid;
        logic [63:0] address;
        logic        is_store;
        logic [7:0]  mask;
        logic [63:0] data;
    } req_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    req_t exp_a[$];
    req_t exp_b[$];
    req_t ra;
    req_t rb;

    logic [3:0] infl_a;
    logic [1:0] infl_b;
    logic       done_a, done_b, err_a, err_b;
`ifdef MEMTRACE_SCHED_STATS_EN
    logic [31:0] sreq_a, scr_a, sbp_a, sreq_b, scr_b, sbp_b;
`endif

    memtrace_lane_scheduler_if a ();
    memtrace_lane_scheduler_if b ();

    always #5 clock = ~clock;

    memtrace_lane_scheduler u_dut_a (
        .clock(clock),
        .reset(reset),
        .bus(a),
        .inflight(infl_a),
        .done(done_a),
        .err_underflow(err_a)
`ifdef MEMTRACE_SCHED_STATS_EN
        ,
        .stat_req_count(sreq_a),
        .stat_credit_stall(scr_a),
        .stat_bp_stall(sbp_a)
`endif
    );

    memtrace_lane_scheduler #(.MAX_INFLIGHT(2)) u_dut_b (
        .clock(clock),
        .reset(reset),
        .bus(b),
        .inflight(infl_b),
        .done(done_b),
        .err_underflow(err_b)
`ifdef MEMTRACE_SCHED_STATS_EN
        ,
        .stat_req_count(sreq_b),
        .stat_credit_stall(scr_b),
        .stat_bp_stall(sbp_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one bundle for a single accept cycle and queues the requests it must produce.
    task automatic send(input bit use_b, input logic [3:0] v, input logic [255:0] addr,
                        input logic [3:0] st, input logic [31:0] mk, input logic [255:0] dat,
                        input logic fin);
        req_t r;
        for (int g = 0; g < 4; g++) begin
            if (v[g]) begin
                r.tid      = 2'(g);
                r.address  = addr[64*g +: 64];
                r.is_store = st[g];
                r.mask     = mk[8*g +: 8];
                r.data     = dat[64*g +: 64];
                if (use_b) exp_b.push_back(r);
                else exp_a.push_back(r);
            end
        end
        if (use_b) begin
            check("b_accept_ready", b.trace_read_ready, 1);
            b.trace_read_valid = v; b.trace_read_address = addr; b.trace_read_is_store = st;
            b.trace_read_store_mask = mk; b.trace_read_data = dat; b.trace_read_finished = fin;
        end else begin
            check("a_accept_ready", a.trace_read_ready, 1);
            a.trace_read_valid = v; a.trace_read_address = addr; a.trace_read_is_store = st;
            a.trace_read_store_mask = mk; a.trace_read_data = dat; a.trace_read_finished = fin;
        end
        @(posedge clock); #1;
        if (use_b) begin
            b.trace_read_valid = '0; b.trace_read_finished = 1'b0;
        end else begin
            a.trace_read_valid = '0; a.trace_read_finished = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        if (reset && a.mem_req_valid && a.mem_req_ready) begin
            check("a_sb_expected", exp_a.size() != 0, 1);
            if (exp_a.size() != 0) begin
                ra = exp_a.pop_front();
                check("a_sb_tid", a.mem_req_tid, ra.tid);
                check("a_sb_addr", a.mem_req_address, ra.address);
                check("a_sb_store", a.mem_req_is_store, ra.is_store);
                check("a_sb_mask", a.mem_req_store_mask, ra.mask);
                check("a_sb_data", a.mem_req_data, ra.data);
            end
        end
    end

    always @(negedge clock) begin
        if (reset && b.mem_req_valid && b.mem_req_ready) begin
            check("b_sb_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                rb = exp_b.pop_front();
                check("b_sb_tid", b.mem_req_tid, rb.tid);
                check("b_sb_addr", b.mem_req_address, rb.address);
                check("b_sb_store", b.mem_req_is_store, rb.is_store);
                check("b_sb_mask", b.mem_req_store_mask, rb.mask);
                check("b_sb_data", b.mem_req_data, rb.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        a.trace_read_valid = '0; a.trace_read_address = '0; a.trace_read_is_store = '0;
        a.trace_read_store_mask = '0; a.trace_read_data = '0; a.trace_read_finished = 1'b0;
        a.mem_req_ready = 1'b0; a.mem_resp_valid = 1'b0;
        b.trace_read_valid = '0; b.trace_read_address = '0; b.trace_read_is_store = '0;
        b.trace_read_store_mask = '0; b.trace_read_data = '0; b.trace_read_finished = 1'b0;
        b.mem_req_ready = 1'b0; b.mem_resp_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready_low", a.trace_read_ready, 0);
        check("rst_req_valid", a.mem_req_valid, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_ready_high", a.trace_read_ready, 1);
        check("rst_inflight", infl_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_tid", a.mem_req_tid, 0);
        check("rst_addr", a.mem_req_address, 0);
        check("rst_data", a.mem_req_data, 0);

        // two sparse lanes issue back to back in ascending tid order
        @(posedge clock); #1;
        a.mem_req_ready = 1'b1;
        send(0, 4'b1010, {64'h300, 64'h2222, 64'h100, 64'h1111}, 4'b0000, 32'h0,
             {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 1'b0);
        @(negedge clock);
        check("t1_first_valid", a.mem_req_valid, 1);
        check("t1_first_tid", a.mem_req_tid, 1);
        @(negedge clock);
        check("t1_second_valid", a.mem_req_valid, 1);
        check("t1_second_tid", a.mem_req_tid, 3);
        @(negedge clock);
        check("t1_ready_back", a.trace_read_ready, 1);
        check("t1_valid_low", a.mem_req_valid, 0);
        check("t1_inflight", infl_a, 2);
        @(posedge clock); #1;
        a.mem_resp_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        a.mem_resp_valid = 1'b0;
        @(negedge clock);
        check("t1_drained", infl_a, 0);

        // backpressure: store held stable for 5 cycles, fires in cycle 6
        @(posedge clock); #1;
        a.mem_req_ready = 1'b0;
        send(0, 4'b0001, {64'h0, 64'h0, 64'h0, 64'h40}, 4'b0001, 32'h0000000F,
             {64'h0, 64'h0, 64'h0, 64'hDEADBEEF}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", a.mem_req_valid, 1);
            check("bp_tid", a.mem_req_tid, 0);
            check("bp_addr", a.mem_req_address, 64'h40);
            check("bp_store", a.mem_req_is_store, 1);
            check("bp_mask", a.mem_req_store_mask, 8'h0F);
            check("bp_data", a.mem_req_data, 64'hDEADBEEF);
            check("bp_inflight", infl_a, 0);
            @(posedge clock); #1;
        end
        a.mem_req_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("bp_fired_inflight", infl_a, 1);
        check("bp_valid_after", a.mem_req_valid, 0);
        @(posedge clock); #1;
        a.mem_resp_valid = 1'b1;
        @(posedge clock); #1;
        a.mem_resp_valid = 1'b0;

        // reset in the middle of ISSUE with three requests outstanding
        send(0, 4'b1111, {64'h3C0, 64'h380, 64'h340, 64'h300}, 4'b0000, 32'h0,
             {64'h13, 64'h12, 64'h11, 64'h10}, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        a.mem_req_ready = 1'b0;
        @(negedge clock);
        check("rm_inflight", infl_a, 3);
        check("rm_pending_tid", a.mem_req_tid, 3);
        check("rm_queue_left", exp_a.size(), 1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("rm_valid", a.mem_req_valid, 0);
        check("rm_inflight_clr", infl_a, 0);
        check("rm_ready_in_reset", a.trace_read_ready, 0);
        exp_a.delete();
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("rm_idle_ready", a.trace_read_ready, 1);
        check("rm_addr_clr", a.mem_req_address, 0);
        check("uf_err_before", err_a, 0);

        // response with nothing outstanding
        @(posedge clock); #1;
        a.mem_resp_valid = 1'b1;
        @(posedge clock); #1;
        a.mem_resp_valid = 1'b0;
        @(negedge clock);
        check("uf_err", err_a, 1);
        check("uf_inflight", infl_a, 0);

        // last bundle with finished, response three cycles later, then done
        @(posedge clock); #1;
        a.mem_req_ready = 1'b1;
        send(0, 4'b0001, {64'h0, 64'h0, 64'h0, 64'h500}, 4'b0000, 32'h0,
             {64'h0, 64'h0, 64'h0, 64'h55}, 1'b1);
        @(posedge clock); #1;
        @(negedge clock);
        check("fin_ready_drain", a.trace_read_ready, 0);
        check("fin_inflight", infl_a, 1);
        check("fin_valid_low", a.mem_req_valid, 0);
        check("fin_done_early", done_a, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        a.mem_resp_valid = 1'b1;
        @(posedge clock); #1;
        a.mem_resp_valid = 1'b0;
        @(negedge clock);
        check("fin_inflight_zero", infl_a, 0);
        check("fin_done_not_yet", done_a, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("fin_done", done_a, 1);
        check("fin_ready_done", a.trace_read_ready, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("fin_done_sticky", done_a, 1);
        check("fin_ready_stays", a.trace_read_ready, 0);

        // credit limit of two on instance b
        @(posedge clock); #1;
        b.mem_req_ready = 1'b1;
        send(1, 4'b1111, {64'h730, 64'h720, 64'h710, 64'h700}, 4'b0100, 32'h8F_4F_2F_1F,
             {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        check("cr_valid_low", b.mem_req_valid, 0);
        check("cr_inflight", infl_b, 2);
        check("cr_tid_next", b.mem_req_tid, 2);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            check("cr_hold", b.mem_req_valid, 0);
        end
        @(posedge clock); #1;
        b.mem_resp_valid = 1'b1;
        @(posedge clock); #1;
        b.mem_resp_valid = 1'b0;
        @(negedge clock);
        check("cr_reassert", b.mem_req_valid, 1);
        check("cr_tid2", b.mem_req_tid, 2);
        check("cr_inflight_one", infl_b, 1);
        for (int i = 0; i < 20 && (exp_b.size() != 0 || infl_b != 0); i++) begin
            @(posedge clock); #1;
            b.mem_resp_valid = (infl_b != 0);
        end
        @(posedge clock); #1;
        b.mem_resp_valid = 1'b0;
        check("cr_queue_empty", exp_b.size(), 0);
        check("cr_inflight_zero", infl_b, 0);
        check("cr_no_err", err_b, 0);

        // finished with no lanes goes straight to drain and done
        @(posedge clock); #1;
        b.trace_read_finished = 1'b1;
        @(posedge clock); #1;
        b.trace_read_finished = 1'b0;
        @(negedge clock);
        check("fo_done_drain", done_b, 0);
        check("fo_ready_drain", b.trace_read_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("fo_done", done_b, 1);

        check("a_queue_empty", exp_a.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
